// File: rtl/apb_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_pkg
// Description : Shared constants and types for the APB 64-bit timer unit:
//               word-offset decode values, CTRL bit positions, compare reset
//               value and the APB transfer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_timer_pkg;

   // Word offsets, decoded from paddr[4:2]
   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_PRESC    = 3'd1;
   localparam logic [2:0] OFF_CNT_LO   = 3'd2;
   localparam logic [2:0] OFF_CNT_HI   = 3'd3;
   localparam logic [2:0] OFF_CMP_LO   = 3'd4;
   localparam logic [2:0] OFF_CMP_HI   = 3'd5;
   localparam logic [2:0] OFF_STATUS   = 3'd6;
   localparam logic [2:0] OFF_UNMAPPED = 3'd7;

   // CTRL register bit positions
   localparam int CTRL_EN           = 0;
   localparam int CTRL_IRQ_EN       = 1;
   localparam int CTRL_CLR_ON_MATCH = 2;

   // Compare register comes out of reset as all ones so a fresh timer never matches early
   localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   // APB transfer state machine
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_core
// Description : Prescaler, 64-bit free-running counter, 64-bit compare and
//               sticky MATCH flag. Register values and per-half write strobes
//               come from the APB register file in the top level.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timer_core #(
   parameter int PRESC_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en,
   input  logic                   clr_on_match,
   input  logic [PRESC_WIDTH-1:0] presc,
   input  logic [63:0]            cmp,
   input  logic                   wr_lo,
   input  logic                   wr_hi,
   input  logic [31:0]            wdata,
   input  logic                   match_clr,
   output logic [63:0]            cnt,
   output logic                   match
);

   logic [PRESC_WIDTH-1:0] pc;
   logic                   tick;
   logic                   hit;
   logic [63:0]            cnt_next;

   // Tick/compare decode and the counter value the tick would produce
   always_comb begin
      tick     = en && (pc == presc);
      hit      = tick && (cnt == cmp);
      cnt_next = cnt;
      if (tick) begin
         cnt_next = (hit && clr_on_match) ? 64'd0 : cnt + 64'd1;
      end
   end

   // Prescaler: counts 0..presc while enabled, parked at 0 when disabled
   always_ff @(posedge clk_i) begin
      if (rst_i || !en || (pc == presc)) begin
         pc <= '0;
      end else begin
         pc <= pc + 1'b1;
      end
   end

   // Counter halves: a bus write to a half overrides that half only; the other
   // half still takes its ticked value (carry is computed from the old count)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else begin
         cnt[31:0]  <= wr_lo ? wdata : cnt_next[31:0];
         cnt[63:32] <= wr_hi ? wdata : cnt_next[63:32];
      end
   end

   // Sticky match flag; a new match beats a simultaneous software clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         match <= 1'b0;
      end else if (hit) begin
         match <= 1'b1;
      end else if (match_clr) begin
         match <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb_timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer_unit
// Description : APB slave wrapper around apb_timer_core. Holds the one-wait-
//               state transfer FSM, address decode, register file and the
//               CNT_HI shadow used for atomic 64-bit counter readout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timer_unit
   import apb_timer_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int PRESC_WIDTH    = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  logic [31:0]               pwdata_i,
   output logic [31:0]               prdata_o,
   output logic                      pready_o,
   output logic                      pslverr_o,
   output logic                      irq_o
);

   apb_state_t             state;
   logic [2:0]             ctrl;
   logic [PRESC_WIDTH-1:0] presc;
   logic [63:0]            cmp;
   logic [31:0]            shadow;
   logic                   wr_q;
   logic [2:0]             idx_q;
   logic [31:0]            wdata_q;

   logic [2:0]             idx;
   logic                   addr_err;
   logic [31:0]            rd_val;
   logic                   commit;
   logic [63:0]            cnt;
   logic                   match;

   // Only paddr[4:0] is decoded; the rest of the address is ignored
   generate
      if (APB_ADDR_WIDTH > 5) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^paddr_i[APB_ADDR_WIDTH-1:5];
      end
   endgenerate

   // Address decode, read mux and write-commit strobe
   always_comb begin
      idx      = paddr_i[4:2];
      addr_err = (paddr_i[1:0] != 2'b00) || (idx == OFF_UNMAPPED);
      commit   = (state == ST_RESP) && wr_q && !pslverr_o;
      case (idx)
         OFF_CTRL:   rd_val = {29'd0, ctrl};
         OFF_PRESC:  rd_val = 32'(presc);
         OFF_CNT_LO: rd_val = cnt[31:0];
         OFF_CNT_HI: rd_val = shadow;
         OFF_CMP_LO: rd_val = cmp[31:0];
         OFF_CMP_HI: rd_val = cmp[63:32];
         OFF_STATUS: rd_val = {31'd0, match};
         default:    rd_val = 32'd0;
      endcase
   end

   // APB transfer FSM: response, error and shadow are captured in the WAIT cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         pready_o  <= 1'b0;
         prdata_o  <= 32'd0;
         pslverr_o <= 1'b0;
         wr_q      <= 1'b0;
         idx_q     <= 3'd0;
         wdata_q   <= 32'd0;
         shadow    <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (psel_i && !penable_i) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!psel_i) begin
                  state <= ST_IDLE;
               end else if (penable_i) begin
                  state     <= ST_RESP;
                  pready_o  <= 1'b1;
                  pslverr_o <= addr_err;
                  prdata_o  <= (pwrite_i || addr_err) ? 32'd0 : rd_val;
                  wr_q      <= pwrite_i;
                  idx_q     <= idx;
                  wdata_q   <= pwdata_i;
                  if (!pwrite_i && !addr_err && (idx == OFF_CNT_LO)) begin
                     shadow <= cnt[63:32];
                  end
               end
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               pready_o  <= 1'b0;
               prdata_o  <= 32'd0;
               pslverr_o <= 1'b0;
               wr_q      <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Configuration registers, updated at the edge that ends RESP
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl  <= 3'd0;
         presc <= '0;
         cmp   <= CMP_RESET;
      end else if (commit) begin
         case (idx_q)
            OFF_CTRL:   ctrl        <= wdata_q[2:0];
            OFF_PRESC:  presc       <= wdata_q[PRESC_WIDTH-1:0];
            OFF_CMP_LO: cmp[31:0]   <= wdata_q;
            OFF_CMP_HI: cmp[63:32]  <= wdata_q;
            default:    ;
         endcase
      end
   end

   // Registered level interrupt
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= match & ctrl[CTRL_IRQ_EN];
      end
   end

   apb_timer_core #(
      .PRESC_WIDTH (PRESC_WIDTH)
   ) u_core (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .en           (ctrl[CTRL_EN]),
      .clr_on_match (ctrl[CTRL_CLR_ON_MATCH]),
      .presc        (presc),
      .cmp          (cmp),
      .wr_lo        (commit && (idx_q == OFF_CNT_LO)),
      .wr_hi        (commit && (idx_q == OFF_CNT_HI)),
      .wdata        (wdata_q),
      .match_clr    (commit && (idx_q == OFF_STATUS) && wdata_q[0]),
      .cnt          (cnt),
      .match        (match)
   );

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_timer_unit
// Description : Directed bench for apb_timer_unit. Transfers push their
//               expected response into a queue; a monitor pops and compares
//               whenever pready_o is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_timer_unit;
   import apb_timer_pkg::*;

   localparam logic [11:0] A_CTRL   = 12'h000;
   localparam logic [11:0] A_PRESC  = 12'h004;
   localparam logic [11:0] A_CNT_LO = 12'h008;
   localparam logic [11:0] A_CNT_HI = 12'h00C;
   localparam logic [11:0] A_CMP_LO = 12'h010;
   localparam logic [11:0] A_CMP_HI = 12'h014;
   localparam logic [11:0] A_STATUS = 12'h018;
   localparam logic [11:0] A_UNMAP  = 12'h01C;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr, irq;

   typedef struct packed {
      logic [11:0] addr;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   apb_timer_unit #(
      .APB_ADDR_WIDTH (12),
      .PRESC_WIDTH    (16)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .psel_i    (psel),
      .penable_i (penable),
      .pwrite_i  (pwrite),
      .paddr_i   (paddr),
      .pwdata_i  (pwdata),
      .prdata_o  (prdata),
      .pready_o  (pready),
      .pslverr_o (pslverr),
      .irq_o     (irq)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every completed transfer must match the oldest expectation
   always @(negedge clk) begin
      if (pready === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pready: got data=%h err=%b with no transfer pending", prdata, pslverr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (prdata !== e.data || pslverr !== e.err) begin
               n_fail++;
               $display("FAIL xfer@%h: got data=%h err=%b expected data=%h err=%b",
                        e.addr, prdata, pslverr, e.data, e.err);
            end
         end
      end
   end

   // One full transfer: setup, one wait-state cycle, response; returns 1ns after the RESP-ending edge
   task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input bit err);
      exp_t e;
      e.addr = a;
      e.err  = err;
      e.data = wr ? 32'd0 : exp;
      exp_q.push_back(e);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      check("wait_state_pready", 64'(pready), 64'd0);
      @(posedge clk); #1;
      check("resp_pready", 64'(pready), 64'd1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp);
      xfer(1'b0, a, 32'd0, exp, 1'b0);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      xfer(1'b1, a, d, 32'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pready", 64'(pready), 64'd0);
      check("rst_prdata", 64'(prdata), 64'd0);
      check("rst_pslverr", 64'(pslverr), 64'd0);
      check("rst_irq", 64'(irq), 64'd0);
      rst = 1'b0;

      // Reset values of every mapped register
      rd(A_CTRL, 32'd0);
      rd(A_PRESC, 32'd0);
      rd(A_CNT_LO, 32'd0);
      rd(A_CNT_HI, 32'd0);
      rd(A_CMP_LO, 32'hFFFF_FFFF);
      rd(A_CMP_HI, 32'hFFFF_FFFF);
      rd(A_STATUS, 32'd0);

      // Prescaler 3: ticks on every 4th edge after EN commits; 40 edges -> 10
      wr(A_PRESC, 32'd3);
      wr(A_CTRL, 32'd1);
      repeat (37) @(posedge clk);
      #1;
      wr(A_CTRL, 32'd0);
      rd(A_CNT_LO, 32'd10);
      rd(A_CNT_HI, 32'd0);
      check("pc_idle", 64'(dut.u_core.pc), 64'd0);

      // Atomic readout across the 32-bit carry
      wr(A_CNT_LO, 32'hFFFF_FFFE);
      wr(A_CNT_HI, 32'd0);
      wr(A_PRESC, 32'd0);
      wr(A_CTRL, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rd(A_CNT_LO, 32'd1);
      rd(A_CNT_HI, 32'd1);
      wr(A_CTRL, 32'd0);

      // Compare 5 with clear-on-match: count 0..5,0,1.. and irq one cycle after the match
      wr(A_CNT_LO, 32'd0);
      wr(A_CNT_HI, 32'd0);
      wr(A_CMP_LO, 32'd5);
      wr(A_CMP_HI, 32'd0);
      wr(A_CTRL, 32'd7);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check($sformatf("cnt_k%0d", k), dut.u_core.cnt, 64'(k % 6));
         check($sformatf("irq_k%0d", k), 64'(irq), (k >= 7) ? 64'd1 : 64'd0);
      end
      // W1C commits on the same edge as the next match: set wins
      repeat (2) @(posedge clk);
      #1;
      wr(A_STATUS, 32'd1);
      rd(A_STATUS, 32'd1);
      @(negedge clk);
      check("irq_after_collision", 64'(irq), 64'd1);
      // W1C away from a match: irq drops one cycle after the commit
      @(posedge clk);
      #1;
      wr(A_STATUS, 32'd1);
      @(negedge clk);
      check("irq_commit_cycle", 64'(irq), 64'd1);
      @(negedge clk);
      check("irq_fall", 64'(irq), 64'd0);
      @(posedge clk);
      #1;
      wr(A_CTRL, 32'd0);
      wr(A_STATUS, 32'd1);
      rd(A_STATUS, 32'd0);
      rd(A_CTRL, 32'd0);

      // Error responses and no side effects
      xfer(1'b0, A_UNMAP, 32'd0, 32'd0, 1'b1);
      xfer(1'b0, 12'h006, 32'd0, 32'd0, 1'b1);
      xfer(1'b1, A_UNMAP, 32'hDEAD_BEEF, 32'd0, 1'b1);
      xfer(1'b1, 12'h002, 32'd7, 32'd0, 1'b1);
      xfer(1'b1, 12'h011, 32'd9, 32'd0, 1'b1);
      rd(A_CTRL, 32'd0);
      rd(A_CMP_LO, 32'd5);

      // Aborted transfer: setup then psel dropped in the WAIT cycle
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_PRESC; pwdata = 32'h55;
      @(posedge clk); #1;
      psel = 1'b0; pwrite = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("abort_pready", 64'(pready), 64'd0);
         @(posedge clk); #1;
      end
      check("abort_fsm_idle", 64'(dut.state), 64'(ST_IDLE));
      rd(A_PRESC, 32'd0);

      // Reset during a write's WAIT cycle
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_PRESC; pwdata = 32'hAA;
      @(posedge clk); #1;
      penable = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rst_mid_pready", 64'(pready), 64'd0);
         @(posedge clk); #1;
      end
      check("rst_mid_fsm_idle", 64'(dut.state), 64'(ST_IDLE));
      rd(A_PRESC, 32'd0);
      rd(A_CMP_LO, 32'hFFFF_FFFF);
      rd(A_CNT_HI, 32'd0);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_timer_unit.md
# apb_timer_unit

APB peripheral that sits directly downstream of the 64-bit-AXI-to-32-bit-APB bridge and is the first slave on its APB segment. It implements a prescaled 64-bit free-running counter with 64-bit compare, a match interrupt and atomic 64-bit counter readout over the 32-bit bus. Every transfer takes exactly one wait state. Register accesses that are unmapped or misaligned complete with PSLVERR.

## Interface
Parameters:
- APB_ADDR_WIDTH, 12, width of paddr_i; only bits [4:2] are decoded, upper bits ignored.
- PRESC_WIDTH, 16, width of the prescaler reload value and the prescaler counter (1..32).

Ports:
- clk_i  in  1  single clock for the whole block
- rst_i  in  1  reset, synchronous, active-high
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  1 = write
- paddr_i  in  APB_ADDR_WIDTH  byte address
- pwdata_i  in  32  write data
- prdata_o  out  32  read data, valid only while pready_o=1, else 0
- pready_o  out  1  transfer complete
- pslverr_o  out  1  error response, valid only while pready_o=1, else 0
- irq_o  out  1  level interrupt = STATUS.MATCH & CTRL.IRQ_EN

## Operation
- Register map (offset):
  - 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 CLR_ON_MATCH; other bits read 0.
  - 0x04 PRESC: [PRESC_WIDTH-1:0], reset 0.
  - 0x08 CNT_LO.
  - 0x0C CNT_HI.
  - 0x10 CMP_LO.
  - 0x14 CMP_HI.
  - 0x18 STATUS: bit0 MATCH, W1C.
  - 0x1C: unmapped.
- Error responses:
  - paddr_i[1:0]!=0 or offset 0x1C -> pslverr_o=1.
  - Writes with error have no effect; reads with error return 0.
- Reset values: all registers 0 except CMP = 64'hFFFF_FFFF_FFFF_FFFF. Outputs: prdata_o=0, pready_o=0, pslverr_o=0, irq_o=0.
- Prescaler:
  - Counter pc counts 0..PRESC. A tick fires when EN=1 and pc==PRESC; pc then returns to 0, otherwise it increments.
  - PRESC=0 gives a tick every cycle.
  - pc resets to 0 whenever EN=0.
- Counter:
  - On a tick, cnt <= cnt+1, modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
  - Match: a tick with cnt==CMP sets MATCH. If CLR_ON_MATCH=1, cnt <= 0 instead of cnt+1.
- Priority, per cycle:
  - An APB write to CNT_LO/CNT_HI overrides the tick for that half; the other half still updates normally (no carry into a written half).
  - A MATCH set and a W1C clear in the same cycle: set wins.
- Atomic read:
  - A read of CNT_LO captures cnt[63:32] into a shadow register.
  - A read of CNT_HI returns the shadow, not the live count.
  - The shadow resets to 0.

## Timing
- Transfer FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT when psel_i=1 & penable_i=0 (setup phase).
  - WAIT -> RESP when psel_i=1 & penable_i=1. In this cycle pready_o=0, read data and error are registered, and the CNT_LO shadow is captured.
  - WAIT -> IDLE when psel_i=0 (aborted transfer, no side effects).
  - RESP -> IDLE unconditionally. In RESP, pready_o=1 and prdata_o/pslverr_o are driven from the registers.
- Writes commit at the clock edge ending RESP. The new value is visible to the counter logic from the next cycle.
- Latency: setup cycle, then 2 access cycles (one wait state). Back-to-back transfers: the next setup phase may occur in the cycle after RESP.
- Read data reflects register contents at the WAIT cycle. A tick in the same WAIT cycle is not included.
- irq_o is registered: it rises 1 cycle after the matching tick edge and falls 1 cycle after the W1C or IRQ_EN=0 write commits.
- rst_i mid-transfer: the FSM returns to IDLE, pready_o=0 next cycle, and the pending write is dropped.

## Structure
- A shared package apb_timer_pkg holds:
  - register offset constants, CTRL bit indices, CMP reset value;
  - the FSM state enum typedef.
- One sub-module, apb_timer_core: prescaler, 64-bit counter, compare, MATCH flag. It takes register values and per-half write strobes as inputs.
- The top level holds the APB FSM, address decode, register file and shadow.

## Test plan
- Reset, then read all offsets -> CTRL=0, PRESC=0, CNT=0, CMP=all ones, STATUS=0, each with exactly one pready_o=0 cycle before pready_o=1.
- PRESC=3, EN=1, wait 40 cycles, stop (EN=0) -> cnt=10 (±1 for the write-commit edge, checked exactly by the model), pc=0.
- CNT_LO=0xFFFF_FFFE, CNT_HI=0, PRESC=0, EN=1; read LO then HI across the carry -> HI returns the shadow consistent with LO (e.g. LO=0x0000_0001, HI=1; never LO=1 with HI=0).
- CMP=5, IRQ_EN=1, CLR_ON_MATCH=1, PRESC=0, EN=1 -> irq_o rises; cnt sequence 0..5,0,1. W1C STATUS=1 in the same cycle as the next match -> MATCH stays 1.
- Read 0x1C and 0x06; write 0x1C -> pslverr_o=1, prdata_o=0, no register changes.
- Setup phase followed by psel_i=0 in the WAIT cycle, then rst_i asserted during a write's WAIT cycle -> no register update, pready_o never asserted, FSM in IDLE.
